// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - instruction fields, opcodes and loader state shared by the CPU slice
package cpu_isa_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int RS_MSB  = 5;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 2;
  localparam int IMM_MSB = 1;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } loader_state_t;

  function automatic logic [1:0] instr_op(input logic [7:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - program byte stream, fetch port and CPU control bundle
interface imem_loader_if;

  logic       load_start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [7:0] read_address;
  logic [7:0] instruction;
  logic       cpu_hold;
  logic [5:0] loaded_count;
  logic       load_err;

  modport master (
    output load_start, in_valid, in_data, in_last, read_address,
    input  in_ready, instruction, cpu_hold, loaded_count, load_err
  );

  modport slave (
    input  load_start, in_valid, in_data, in_last, read_address,
    output in_ready, instruction, cpu_hold, loaded_count, load_err
  );

endinterface

// File: rtl/imem_array.sv
// rtl/imem_array.sv - DEPTHx8 instruction store, sync write/clear, async read
module imem_array #(
  parameter int         DEPTH = 32,
  parameter logic [7:0] FILL  = 8'h00,
  parameter int         AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [7:0]    i_raddr,
  output logic [7:0]    o_rdata
);

  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= FILL;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Out-of-range fetches return FILL so the CPU sees a harmless opcode
  always_comb begin
    o_rdata = FILL;
    if ({1'b0, i_raddr} < DEPTH_W) o_rdata = r_mem[i_raddr[AW-1:0]];
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a program byte stream into imem and gates CPU reset
module imem_loader
  import cpu_isa_pkg::*;
#(
  parameter int         DEPTH = 32,
  parameter logic [7:0] FILL  = 8'h00
) (
  input  logic          clk50,
  input  logic          reset,
  imem_loader_if.slave  lb
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  loader_state_t r_state;
  logic [AW-1:0] r_wr_ptr;
  logic          r_in_ready;
  logic          r_cpu_hold;
  logic          r_load_err;
  logic [5:0]    r_loaded_count;
  logic          w_accept;
  logic          w_at_end;

  assign w_accept = lb.in_valid && r_in_ready;
  assign w_at_end = (r_wr_ptr == LAST_ADDR);

  always_ff @(posedge clk50) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_wr_ptr       <= '0;
      r_in_ready     <= 1'b0;
      r_cpu_hold     <= 1'b1;
      r_loaded_count <= '0;
      r_load_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (lb.load_start) begin
            r_state        <= ST_LOAD;
            r_wr_ptr       <= '0;
            r_in_ready     <= 1'b1;
            r_cpu_hold     <= 1'b1;
            r_loaded_count <= '0;
            r_load_err     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_wr_ptr       <= r_wr_ptr + 1'b1;
            r_loaded_count <= r_loaded_count + 6'd1;
            // A full array without in_last ends the load as truncated
            if (lb.in_last || w_at_end) begin
              r_state    <= ST_RUN;
              r_in_ready <= 1'b0;
              r_cpu_hold <= 1'b0;
              r_load_err <= !lb.in_last;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_cpu_hold <= 1'b1;
        end
      endcase
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .FILL  (FILL),
    .AW    (AW)
  ) u_array (
    .i_clk    (clk50),
    .i_resetn (reset),
    .i_we     (w_accept),
    .i_waddr  (r_wr_ptr),
    .i_wdata  (lb.in_data),
    .i_raddr  (lb.read_address),
    .o_rdata  (lb.instruction)
  );

  assign lb.in_ready     = r_in_ready;
  assign lb.cpu_hold     = r_cpu_hold;
  assign lb.loaded_count = r_loaded_count;
  assign lb.load_err     = r_load_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  logic clk50 = 1'b0;
  logic reset = 1'b0;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(32), .FILL(8'h00)) dut (
    .clk50 (clk50),
    .reset (reset),
    .lb    (bus)
  );

  always #5 clk50 = ~clk50;

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;

  wr_t        sb_q [$];
  logic [7:0] src_q [$];
  logic [7:0] exp_mem [32];
  vec_t       tbl [6];
  logic       m_ready, m_hold, m_err;
  logic [5:0] m_count;
  int         m_wr;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk50);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(m_ready));
    check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(m_hold));
    check({tag, "_loaded_count"}, 32'(bus.loaded_count), 32'(m_count));
    check({tag, "_load_err"}, 32'(bus.load_err), 32'(m_err));
  endtask

  task automatic do_reset;
    reset = 1'b0;
    bus.load_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    tick;
    reset = 1'b1;
    m_ready = 1'b0; m_hold = 1'b1; m_err = 1'b0; m_count = 6'd0; m_wr = 0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;
    sb_q.delete();
  endtask

  task automatic start_load;
    bus.load_start = 1'b1;
    tick;
    bus.load_start = 1'b0;
    m_ready = 1'b1; m_hold = 1'b1; m_err = 1'b0; m_count = 6'd0; m_wr = 0;
    check_status("start");
  endtask

  // Offers src_q bytes; gaps drops in_valid on alternate cycles with junk data/last
  task automatic stream(input bit gaps, input bit with_last);
    int i = 0;
    int cyc = 0;
    bit skip = 1'b0;
    bit acc;
    bit lst;
    while (m_ready && i < src_q.size() && cyc < 200) begin
      if (gaps && skip) begin
        bus.in_valid = 1'b0; bus.in_data = 8'hFF; bus.in_last = 1'b1;
      end else begin
        bus.in_valid = 1'b1; bus.in_data = src_q[i];
        bus.in_last = with_last && (i == src_q.size() - 1);
      end
      acc = bus.in_valid && m_ready;
      lst = bus.in_last;
      if (acc) begin
        bus.read_address = 8'(m_wr);
        #1;
        check("same_cycle_old", 32'(bus.instruction), 32'(exp_mem[m_wr]));
      end
      tick;
      if (acc) begin
        exp_mem[m_wr] = src_q[i];
        sb_q.push_back(wr_t'{5'(m_wr), src_q[i]});
        m_count = m_count + 6'd1;
        if (lst || m_wr == 31) begin
          m_ready = 1'b0; m_hold = 1'b0; m_err = !lst;
        end
        check("same_cycle_new", 32'(bus.instruction), 32'(exp_mem[m_wr]));
        m_wr++;
        i++;
      end
      check_status("stream");
      skip = !skip;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    if (cyc >= 200) check("stream_budget", 32'(cyc), 32'd0);
  endtask

  task automatic drain;
    wr_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.read_address = {3'b000, e.addr};
      #1;
      check("sb_fetch", 32'(bus.instruction), 32'(e.data));
    end
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 32; a++) begin
      bus.read_address = 8'(a);
      #1;
      check(tag, 32'(bus.instruction), 32'(exp_mem[a]));
    end
  endtask

  task automatic run_table;
    for (int k = 0; k < 6; k++) begin
      bus.read_address = tbl[k].addr;
      #1;
      check("table_fetch", 32'(bus.instruction), 32'(tbl[k].exp));
    end
  endtask

  initial begin
    tbl[0] = '{8'd3,   8'hA9};
    tbl[1] = '{8'd7,   8'h00};
    tbl[2] = '{8'd40,  8'h00};
    tbl[3] = '{8'd0,   8'h49};
    tbl[4] = '{8'd4,   8'h4D};
    tbl[5] = '{8'd255, 8'h00};

    bus.load_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.in_last = 1'b0;
    bus.read_address = 8'h00;

    do_reset;
    check_status("reset");
    sweep("reset_sweep");

    src_q = '{8'h49, 8'hC1, 8'h18, 8'hA9, 8'h4D};
    start_load;
    stream(1'b0, 1'b1);
    check("prog5_count", 32'(bus.loaded_count), 32'd5);
    check("prog5_hold", 32'(bus.cpu_hold), 32'd0);
    drain;
    run_table;

    do_reset;
    start_load;
    stream(1'b1, 1'b1);
    check("gap_count", 32'(bus.loaded_count), 32'd5);
    drain;
    sweep("gap_sweep");
    run_table;

    src_q.delete();
    for (int b = 0; b < 33; b++) src_q.push_back(8'(b));
    start_load;
    stream(1'b0, 1'b0);
    check("ovf_err", 32'(bus.load_err), 32'd1);
    check("ovf_count", 32'(bus.loaded_count), 32'd32);
    check("ovf_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1; bus.in_data = 8'h20; bus.read_address = 8'd0;
    tick;
    bus.in_valid = 1'b0;
    check("ovf_extra_ready", 32'(bus.in_ready), 32'd0);
    check("ovf_extra_mem0", 32'(bus.instruction), 32'(exp_mem[0]));
    check("ovf_extra_count", 32'(bus.loaded_count), 32'd32);
    drain;
    bus.read_address = 8'd31;
    #1;
    check("ovf_addr31", 32'(bus.instruction), 32'h1F);

    src_q = '{8'hC0};
    start_load;
    stream(1'b0, 1'b1);
    drain;
    sweep("reload_sweep");
    bus.read_address = 8'd0;
    #1;
    check("reload_mem0", 32'(bus.instruction), 32'hC0);
    bus.read_address = 8'd4;
    #1;
    check("reload_mem4", 32'(bus.instruction), 32'h04);
    check("reload_err", 32'(bus.load_err), 32'd0);
    check("reload_count", 32'(bus.loaded_count), 32'd1);

    src_q = '{8'h11, 8'h22, 8'h33};
    start_load;
    stream(1'b0, 1'b0);
    check("abort_ready_before", 32'(bus.in_ready), 32'd1);
    do_reset;
    check_status("abort");
    sweep("abort_sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the 8-bit instruction memory the single-cycle CPU fetches from. Accepts a program as a byte stream over a valid/ready handshake, stores it in a 32×8 instruction array, and holds the CPU in reset while loading. Once loading finishes it releases the CPU and serves combinational fetches on the CPU's 8-bit read address. It replaces hard-wired instruction ROMs in board tops.

## Interface
Parameters:
- DEPTH, 32, number of instruction bytes; address width is clog2(DEPTH).
- FILL, 8'h00, value returned for fetches at or beyond DEPTH, and reset contents of every entry.

Ports:
- clk50  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- load_start  in  1  single-cycle request to (re)load a program.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  instruction byte {op[7:6], rs[5:4], rt[3:2], imm/funct[1:0]}.
- in_last  in  1  qualifies the final byte of the program.
- in_ready  out  1  loader accepts a byte this cycle.
- read_address  in  8  CPU fetch address.
- instruction  out  8  fetched instruction byte.
- cpu_hold  out  1  high holds the CPU in reset.
- loaded_count  out  6  bytes written by the most recent load (0..32).
- load_err  out  1  sticky flag: the previous load was truncated at DEPTH.

## Operation
- States: IDLE, LOAD, RUN.
- Reset (reset==0 at an edge) forces the following:
  - state IDLE; all entries FILL; write pointer 0.
  - in_ready 0, cpu_hold 1, loaded_count 0, load_err 0.
- IDLE:
  - cpu_hold 1, in_ready 0.
  - load_start → LOAD.
- LOAD:
  - in_ready 1.
  - On accept (in_valid && in_ready), write in_data to mem[wr_ptr] and increment wr_ptr; loaded_count tracks wr_ptr.
  - Accept with in_last → RUN.
  - Accept at wr_ptr==DEPTH-1 without in_last → RUN, and load_err is set. Any further bytes are not accepted.
  - load_start is ignored in LOAD.
  - in_data is ignored when in_valid==0.
- RUN:
  - cpu_hold 0, in_ready 0.
  - load_start → LOAD. On entering LOAD: wr_ptr=0, loaded_count=0, load_err=0. Old contents are kept until overwritten.
- Entering LOAD from either IDLE or RUN clears wr_ptr, loaded_count and load_err.
- Fetch path:
  - instruction = mem[read_address] when read_address < DEPTH, otherwise FILL.
  - The path is purely combinational in every state.
- Simultaneous events:
  - Reset overrides everything.
  - A write and a fetch to the same address in the same cycle: the fetch returns the old value. The new value is visible after the edge.
- A zero-length load is not possible. The shortest program is one byte carrying in_last.

## Timing
- in_ready, cpu_hold, loaded_count and load_err are registered and change only at clock edges.
- load_start sampled at edge N: state LOAD, cpu_hold 1, in_ready 1 from edge N onward. The first accept is possible at edge N+1.
- Throughput is one byte per cycle while in_valid stays high.
- Final accept at edge M: cpu_hold 0, in_ready 0 and loaded_count final from edge M. The CPU runs from address 0 on edge M+1.
- Fetch latency is 0 cycles: address to instruction is combinational.
- Reset mid-load aborts the load. All entries return to FILL and the state is IDLE.

## Structure
- Shared package cpu_isa_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_J=2'b11;
  - field bit positions of the 8-bit instruction;
  - the loader state enum.
- One sub-module, imem_array: DEPTH×8 register array with synchronous write enable, asynchronous read and synchronous clear. The FSM, pointer and flags live in imem_loader.

## Test plan
- Reset, then read_address 0..31 → instruction 8'h00, cpu_hold 1, in_ready 0.
- load_start; stream 8'h49, 8'hC1, 8'h18, 8'hA9, 8'h4D with in_last on the 5th:
  - loaded_count 5, cpu_hold 0 after the final edge;
  - read_address 3 → 8'hA9, 7 → 8'h00, 40 → 8'h00.
- Toggle in_valid every other cycle during the load: only valid cycles write, and the final contents are identical to the previous case.
- Stream 33 bytes 8'h00..8'h20 without in_last:
  - 32 bytes stored, load_err 1, loaded_count 32, in_ready 0 after the 32nd;
  - read_address 31 → 8'h1F.
- In RUN, assert load_start then load 1 byte 8'hC0 with in_last:
  - cpu_hold high from the load_start edge until the final accept;
  - mem[0]=8'hC0, mem[1..4] keep old values, load_err cleared.
- Assert reset after 3 bytes of a load: state IDLE, all fetches 8'h00, cpu_hold 1, loaded_count 0.
